// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg: line symbols and receiver types shared by
// the USB low-speed receive path and its DPLL.
package usb_rx_pkg;

   // {D+, D-}; low-speed idle (J) drives D- high
   typedef enum logic [1:0] {
      SE0 = 2'b00,
      J   = 2'b01,
      K   = 2'b10,
      SE1 = 2'b11
   } d_port_t;

   typedef enum logic [2:0] {
      IDLE,
      SYNC,
      DATA,
      EOP_WAIT,
      ERR_WAIT
   } rx_state_t;

   localparam int         CLK_DIV      = 16;
   localparam logic [2:0] SYNC_ZEROS   = 3'd5;
   localparam logic [6:0] RESET_CYCLES = 7'd60;
   localparam logic [7:0] SYNC_BYTE    = 8'h80;

   // mid-bit sample point of the 16-clk bit cell
   localparam logic [3:0] STROBE_PHASE = 4'd7;
   localparam logic [2:0] STUFF_ONES   = 3'd6;
   // J strobes that prove the bus idle after an error
   localparam logic [3:0] IDLE_JS      = 4'd8;

   function automatic logic is_jk(d_port_t s);
      return (s == J) || (s == K);
   endfunction

endpackage

// File: rtl/usb_rx_dpll.sv
// usb_rx_dpll: 2-FF synchronizer and bit-phase recovery;
// strobes mid-bit, re-centred on every J<->K edge.
module usb_rx_dpll
   import usb_rx_pkg::*;
(
   input  logic    clk,
   input  logic    reset_n,
   input  d_port_t d_i,
   output d_port_t sym,
   output logic    strobe
);

   d_port_t    r_sync1;
   d_port_t    r_sync2;
   d_port_t    r_last_jk;
   logic [3:0] r_phase;
   logic       w_jk;
   logic       w_trans;

   assign w_jk    = is_jk(r_sync2);
   assign w_trans = w_jk && (r_sync2 != r_last_jk);

   // A strobe coinciding with an edge would sample the
   // new bit twice once the phase restarts, so mask it.
   assign strobe = (r_phase == STROBE_PHASE) && !w_trans;
   assign sym    = r_sync2;

   // bring the asynchronous line into the clk domain
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= J;
         r_sync2 <= J;
      end else begin
         r_sync1 <= d_i;
         r_sync2 <= r_sync1;
      end
   end

   // free-running phase, cleared on J/K edges only
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_phase   <= 4'd0;
         r_last_jk <= J;
      end else begin
         if (w_trans) begin
            r_phase <= 4'd0;
         end else begin
            r_phase <= r_phase + 4'd1;
         end
         if (w_jk) begin
            r_last_jk <= r_sync2;
         end
      end
   end

endmodule

// File: rtl/usb_rx.sv
// usb_rx: USB low-speed receiver; SYNC hunt, NRZI decode,
// unstuffing, byte assembly, EOP/error and bus reset.
module usb_rx
   import usb_rx_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  d_port_t    d_i,
   input  logic       rx_en,
   output logic [7:0] data,
   output logic       valid,
   output logic       active,
   output logic       eop,
   output logic       error,
   output logic       bus_reset
);

   d_port_t    w_sym;
   logic       w_strobe;
   logic       w_jk;
   logic       w_bit;
   logic [7:0] w_byte;

   rx_state_t  r_state;
   d_port_t    r_prev;
   logic [2:0] r_zeros;
   logic [2:0] r_ones;
   logic [2:0] r_bits;
   logic [3:0] r_jcnt;
   logic [7:0] r_shift;
   logic [7:0] r_data;
   logic       r_valid;
   logic       r_active;
   logic       r_eop;
   logic       r_error;
   logic [6:0] r_se0_cnt;
   logic       r_bus_reset;

   usb_rx_dpll u_dpll (
      .clk     (clk),
      .reset_n (reset_n),
      .d_i     (d_i),
      .sym     (w_sym),
      .strobe  (w_strobe)
   );

   assign w_jk   = is_jk(w_sym);
   assign w_bit  = (w_sym == r_prev);
   assign w_byte = {w_bit, r_shift[7:1]};

   assign data      = r_data;
   assign valid     = r_valid;
   assign active    = r_active;
   assign eop       = r_eop;
   assign error     = r_error;
   assign bus_reset = r_bus_reset;

   // NRZI reference: last J/K level seen at a strobe
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_prev <= J;
      end else if (w_strobe && w_jk) begin
         r_prev <= w_sym;
      end
   end

   // packet FSM with unstuffing and byte assembly
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= IDLE;
         r_zeros  <= 3'd0;
         r_ones   <= 3'd0;
         r_bits   <= 3'd0;
         r_jcnt   <= 4'd0;
         r_shift  <= 8'd0;
         r_data   <= 8'd0;
         r_valid  <= 1'b0;
         r_active <= 1'b0;
         r_eop    <= 1'b0;
         r_error  <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         r_eop   <= 1'b0;
         r_error <= 1'b0;
         if (!rx_en) begin
            r_state  <= IDLE;
            r_active <= 1'b0;
         end else if (w_strobe) begin
            case (r_state)
               IDLE: begin
                  if (w_sym == K && r_prev == J) begin
                     r_state <= SYNC;
                     r_zeros <= 3'd1;
                  end
               end
               SYNC: begin
                  if (!w_jk) begin
                     r_state <= IDLE;
                  end else if (!w_bit) begin
                     if (r_zeros != 3'd7) begin
                        r_zeros <= r_zeros + 3'd1;
                     end
                  end else if (r_zeros >= SYNC_ZEROS) begin
                     r_state  <= DATA;
                     r_active <= 1'b1;
                     r_ones   <= 3'd0;
                     r_bits   <= 3'd0;
                  end else begin
                     r_state <= IDLE;
                  end
               end
               DATA: begin
                  if (w_sym == SE0) begin
                     if (r_bits != 3'd0) begin
                        r_error  <= 1'b1;
                        r_active <= 1'b0;
                        r_jcnt   <= 4'd0;
                        r_state  <= ERR_WAIT;
                     end else begin
                        r_state <= EOP_WAIT;
                     end
                  end else if (w_sym == SE1) begin
                     r_error  <= 1'b1;
                     r_active <= 1'b0;
                     r_jcnt   <= 4'd0;
                     r_state  <= ERR_WAIT;
                  end else if (r_ones == STUFF_ONES) begin
                     if (w_bit) begin
                        r_error  <= 1'b1;
                        r_active <= 1'b0;
                        r_jcnt   <= 4'd0;
                        r_state  <= ERR_WAIT;
                     end else begin
                        r_ones <= 3'd0;
                     end
                  end else begin
                     r_ones  <= w_bit ? r_ones + 3'd1 : 3'd0;
                     r_shift <= w_byte;
                     r_bits  <= r_bits + 3'd1;
                     if (r_bits == 3'd7) begin
                        r_data  <= w_byte;
                        r_valid <= 1'b1;
                     end
                  end
               end
               EOP_WAIT: begin
                  if (w_sym == J) begin
                     r_eop    <= 1'b1;
                     r_active <= 1'b0;
                     r_state  <= IDLE;
                  end else if (w_sym != SE0) begin
                     r_error  <= 1'b1;
                     r_active <= 1'b0;
                     r_jcnt   <= 4'd0;
                     r_state  <= ERR_WAIT;
                  end
               end
               ERR_WAIT: begin
                  r_active <= 1'b0;
                  if (w_sym == J) begin
                     if (r_jcnt == IDLE_JS - 4'd1) begin
                        r_state <= IDLE;
                     end else begin
                        r_jcnt <= r_jcnt + 4'd1;
                     end
                  end else begin
                     r_jcnt <= 4'd0;
                  end
               end
               default: begin
                  r_state <= IDLE;
               end
            endcase
         end
      end
   end

   // saturating SE0 run length drives the bus_reset level
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_se0_cnt   <= 7'd0;
         r_bus_reset <= 1'b0;
      end else if (w_sym == SE0) begin
         if (r_se0_cnt != 7'd127) begin
            r_se0_cnt <= r_se0_cnt + 7'd1;
         end
         if (r_se0_cnt >= RESET_CYCLES - 7'd1) begin
            r_bus_reset <= 1'b1;
         end
      end else begin
         r_se0_cnt   <= 7'd0;
         r_bus_reset <= 1'b0;
      end
   end

endmodule

// File: tb/tb_usb_rx.sv
// tb_usb_rx: directed and random packets for usb_rx,
// checked against the byte lists the bench transmits.
`timescale 1ns/1ps
module tb_usb_rx;
   import usb_rx_pkg::*;

   logic       clk = 1'b0;
   logic       reset_n;
   d_port_t    d_i;
   logic       rx_en;
   logic [7:0] data;
   logic       valid;
   logic       active;
   logic       eop;
   logic       error;
   logic       bus_reset;

   usb_rx dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .d_i       (d_i),
      .rx_en     (rx_en),
      .data      (data),
      .valid     (valid),
      .active    (active),
      .eop       (eop),
      .error     (error),
      .bus_reset (bus_reset)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] got_q[$];
   logic [7:0] pkt[$];
   int         eop_cnt = 0;
   int         err_cnt = 0;
   logic       br_seen = 1'b0;
   d_port_t    lvl = J;
   int         ones = 0;
   bit         jitter = 1'b0;
   bit         alt = 1'b0;

   task automatic chk(string tag, logic [31:0] obs,
                      logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
      end
   endtask

   // record DUT events and check pulse invariants
   always @(negedge clk) begin
      if (reset_n) begin
         if (valid) got_q.push_back(data);
         if (eop) eop_cnt++;
         if (error) err_cnt++;
         if (bus_reset) br_seen = 1'b1;
         if (eop || error) begin
            chk("eop_err_same_clk", {31'd0, eop & error}, 0);
            chk("active_at_end", {31'd0, active}, 0);
         end
         if (valid) chk("valid_with_eop", {31'd0, eop}, 0);
      end
   end

   task automatic hold(d_port_t s, int n);
      d_i = s;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic line(d_port_t s);
      int n;
      n = CLK_DIV;
      if (jitter) begin
         n = alt ? CLK_DIV + 1 : CLK_DIV - 1;
         alt = !alt;
      end
      hold(s, n);
   endtask

   task automatic send_bit(bit b);
      if (!b) lvl = (lvl == J) ? K : J;
      line(lvl);
   endtask

   task automatic send_sync();
      logic [7:0] s;
      s = SYNC_BYTE;
      for (int i = 0; i < 8; i++) send_bit(s[i]);
      ones = 0;
   endtask

   task automatic send_byte(logic [7:0] b);
      for (int i = 0; i < 8; i++) begin
         send_bit(b[i]);
         ones = b[i] ? ones + 1 : 0;
         if (ones == 6) begin
            send_bit(1'b0);
            ones = 0;
         end
      end
   endtask

   task automatic send_eop();
      line(SE0);
      line(SE0);
      line(J);
      lvl = J;
   endtask

   task automatic idle(int n);
      hold(J, n);
      lvl = J;
   endtask

   task automatic run_packet(string tag);
      int e0;
      int r0;
      e0 = eop_cnt;
      r0 = err_cnt;
      got_q.delete();
      send_sync();
      foreach (pkt[i]) send_byte(pkt[i]);
      send_eop();
      idle(40);
      chk({tag, "_nbytes"}, got_q.size(), pkt.size());
      for (int i = 0; i < pkt.size() && i < got_q.size(); i++)
         chk($sformatf("%s_byte%0d", tag, i), got_q[i], pkt[i]);
      chk({tag, "_eop"}, eop_cnt - e0, 1);
      chk({tag, "_err"}, err_cnt - r0, 0);
      chk({tag, "_active"}, {31'd0, active}, 0);
   endtask

   initial begin
      int e0;
      int r0;
      logic [7:0] b;
      reset_n = 1'b0;
      d_i     = J;
      rx_en   = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_data", data, 0);
      chk("rst_valid", {31'd0, valid}, 0);
      chk("rst_active", {31'd0, active}, 0);
      chk("rst_eop", {31'd0, eop}, 0);
      chk("rst_error", {31'd0, error}, 0);
      chk("rst_bus_reset", {31'd0, bus_reset}, 0);
      reset_n = 1'b1;

      // single byte
      idle(200);
      pkt.delete();
      pkt.push_back(8'hC3);
      run_packet("c3");

      // two bytes with stuffed bits
      idle(200);
      pkt.delete();
      pkt.push_back(8'hFF);
      pkt.push_back(8'h3F);
      run_packet("stuff");

      // seven ones without a stuff bit
      idle(200);
      e0 = eop_cnt;
      r0 = err_cnt;
      got_q.delete();
      send_sync();
      for (int i = 0; i < 3; i++) send_bit(1'b1);
      chk("stufferr_active_on", {31'd0, active}, 1);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      send_eop();
      idle(40);
      chk("stufferr_err", err_cnt - r0, 1);
      chk("stufferr_eop", eop_cnt - e0, 0);
      chk("stufferr_valid", got_q.size(), 0);
      chk("stufferr_active", {31'd0, active}, 0);

      // 15/17 clk bit cells
      idle(200);
      jitter = 1'b1;
      alt    = 1'b0;
      pkt.delete();
      pkt.push_back(8'hA5);
      pkt.push_back(8'h5A);
      run_packet("jitter");
      jitter = 1'b0;

      // bus reset threshold
      idle(50);
      br_seen = 1'b0;
      hold(SE0, 59);
      hold(J, 20);
      chk("se0_59", {31'd0, br_seen}, 0);
      br_seen = 1'b0;
      hold(SE0, 60);
      hold(J, 3);
      chk("se0_60", {31'd0, br_seen}, 1);
      chk("se0_60_clear", {31'd0, bus_reset}, 0);
      hold(SE0, 100);
      chk("se0_100", {31'd0, bus_reset}, 1);
      hold(J, 2);
      chk("se0_hold_2", {31'd0, bus_reset}, 1);
      hold(J, 1);
      chk("se0_clear_3", {31'd0, bus_reset}, 0);

      // abort mid-byte
      idle(200);
      e0 = eop_cnt;
      r0 = err_cnt;
      got_q.delete();
      b = 8'($urandom);
      send_sync();
      for (int i = 0; i < 4; i++) send_bit(b[i]);
      chk("abort_active_on", {31'd0, active}, 1);
      rx_en = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_active_off", {31'd0, active}, 0);
      for (int i = 4; i < 8; i++) send_bit(b[i]);
      send_eop();
      idle(40);
      chk("abort_valid", got_q.size(), 0);
      chk("abort_eop", eop_cnt - e0, 0);
      chk("abort_err", err_cnt - r0, 0);
      rx_en = 1'b1;
      idle(200);
      pkt.delete();
      pkt.push_back(8'($urandom));
      pkt.push_back(8'($urandom));
      run_packet("after_abort");

      // random packets, random bit-cell jitter
      for (int p = 0; p < 6; p++) begin
         int n;
         jitter = 1'($urandom_range(0, 1));
         alt    = 1'b0;
         n      = $urandom_range(1, 4);
         pkt.delete();
         for (int i = 0; i < n; i++)
            pkt.push_back(8'($urandom));
         idle(200);
         run_packet($sformatf("rnd%0d", p));
      end
      jitter = 1'b0;

      idle(20);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
